// File: rtl/apb_gpio_ctrl.sv
// apb_gpio_ctrl: APB3 GPIO controller with per-pin direction, synchronised inputs,
// edge/level interrupts with write-1-to-clear status and optional per-pin debounce.
//
// Optional feature macro: GPIO_DEBOUNCE_EN (adds DEBOUNCE register at 0x20 and counters).
//
// Ports:
//   PCLK, PRESETN        clock, asynchronous active-low reset
//   PSEL/PENABLE/PWRITE  APB control
//   PADDR[7:0]           byte address (word aligned)
//   PWDATA/PRDATA        APB write / read data (32 bit)
//   PREADY, PSLVERR      always ready; error on unmapped access or write to DATA_IN
//   GPIO_IN              asynchronous pad inputs
//   GPIO_OUT, GPIO_OE    registered pad outputs and output enables
//   INT, INT_OR          registered per-pin interrupts and their OR
module apb_gpio_ctrl #(
    parameter int unsigned        IO_NUM      = 8,
    parameter int unsigned        SYNC_STAGES = 2,
    parameter logic [IO_NUM-1:0]  OUT_RESET   = '0,
    parameter logic [IO_NUM-1:0]  DIR_RESET   = '0
) (
    input  logic              PCLK,
    input  logic              PRESETN,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [7:0]        PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    input  logic [IO_NUM-1:0] GPIO_IN,
    output logic [IO_NUM-1:0] GPIO_OUT,
    output logic [IO_NUM-1:0] GPIO_OE,
    output logic [IO_NUM-1:0] INT,
    output logic              INT_OR
);

    localparam logic [7:0] AddrDataOut = 8'h00;
    localparam logic [7:0] AddrDir     = 8'h04;
    localparam logic [7:0] AddrDataIn  = 8'h08;
    localparam logic [7:0] AddrIntEn   = 8'h0C;
    localparam logic [7:0] AddrIntMode = 8'h10;
    localparam logic [7:0] AddrIntPol  = 8'h14;
    localparam logic [7:0] AddrIntBoth = 8'h18;
    localparam logic [7:0] AddrStatus  = 8'h1C;
    localparam logic [7:0] AddrDebounce = 8'h20;

    logic [IO_NUM-1:0] data_out_q, data_out_d, dir_q, dir_d;
    logic [IO_NUM-1:0] int_en_q, int_en_d, int_mode_q, int_mode_d;
    logic [IO_NUM-1:0] int_pol_q, int_pol_d, int_both_q, int_both_d;
    logic [IO_NUM-1:0] status_q, status_d, prev_q, prev_d, int_q, int_d;
    logic              int_or_q, int_or_d;
    logic [SYNC_STAGES-1:0][IO_NUM-1:0] sync_q, sync_d;

    logic [IO_NUM-1:0] sync_out, cond_in, wdata, rise, fall, edge_ev, lvl_ev, set, clr;
    logic              access, mapped, slv_err, wr_en;
    logic [31:0]       rdata;
    logic              unused_pwdata;

    assign unused_pwdata = ^PWDATA;
    assign wdata         = PWDATA[IO_NUM-1:0];
    assign sync_out      = sync_q[SYNC_STAGES-1];

    // Address decode and error response
    always_comb begin
        access = PSEL & PENABLE;
        unique case (PADDR)
            AddrDataOut, AddrDir, AddrDataIn, AddrIntEn,
            AddrIntMode, AddrIntPol, AddrIntBoth, AddrStatus: mapped = 1'b1;
`ifdef GPIO_DEBOUNCE_EN
            AddrDebounce: mapped = 1'b1;
`endif
            default: mapped = 1'b0;
        endcase
        slv_err = access & (~mapped | (PWRITE & (PADDR == AddrDataIn)));
        wr_en   = access & PWRITE & ~slv_err;
    end

    assign PSLVERR = slv_err;
    assign PREADY  = 1'b1;

`ifdef GPIO_DEBOUNCE_EN
    logic [15:0]              deb_cfg_q, deb_cfg_d;
    logic [IO_NUM-1:0][15:0]  cnt_q, cnt_d;
    logic [IO_NUM-1:0]        deb_val_q, deb_val_d;
    logic                     deb_wr;

    always_comb begin
        deb_wr    = wr_en & (PADDR == AddrDebounce);
        deb_cfg_d = deb_wr ? PWDATA[15:0] : deb_cfg_q;
        cnt_d     = cnt_q;
        deb_val_d = deb_val_q;
        for (int i = 0; i < IO_NUM; i++) begin
            if (deb_wr) begin
                cnt_d[i] = '0;
            end else if (sync_out[i] == deb_val_q[i]) begin
                cnt_d[i] = '0;
            end else if (({1'b0, cnt_q[i]} + 17'd1) >= {1'b0, deb_cfg_q}) begin
                // Input has differed for DEBOUNCE consecutive cycles: accept it
                deb_val_d[i] = sync_out[i];
                cnt_d[i]     = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 16'd1;
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            deb_cfg_q <= '0;
            cnt_q     <= '0;
            deb_val_q <= '0;
        end else begin
            deb_cfg_q <= deb_cfg_d;
            cnt_q     <= cnt_d;
            deb_val_q <= deb_val_d;
        end
    end

    // DEBOUNCE=0 bypasses the filter with no added latency
    assign cond_in = (deb_cfg_q == 16'd0) ? sync_out : deb_val_q;
`else
    assign cond_in = sync_out;
`endif

    // Event detection and next-state for all registers
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], GPIO_IN};
        prev_d  = cond_in;
        rise    = cond_in & ~prev_q;
        fall    = ~cond_in & prev_q;
        edge_ev = (int_both_q & (rise | fall)) |
                  (~int_both_q & ((int_pol_q & rise) | (~int_pol_q & fall)));
        lvl_ev  = ~(cond_in ^ int_pol_q);
        set     = ((int_mode_q & edge_ev) | (~int_mode_q & lvl_ev)) & int_en_q;

        data_out_d = (wr_en && PADDR == AddrDataOut) ? wdata : data_out_q;
        dir_d      = (wr_en && PADDR == AddrDir)     ? wdata : dir_q;
        int_en_d   = (wr_en && PADDR == AddrIntEn)   ? wdata : int_en_q;
        int_mode_d = (wr_en && PADDR == AddrIntMode) ? wdata : int_mode_q;
        int_pol_d  = (wr_en && PADDR == AddrIntPol)  ? wdata : int_pol_q;
        int_both_d = (wr_en && PADDR == AddrIntBoth) ? wdata : int_both_q;
        clr        = (wr_en && PADDR == AddrStatus)  ? wdata : '0;

        // A new event wins over a simultaneous write-1-to-clear
        status_d = (status_q & ~clr) | set;
        int_d    = status_d & int_en_d;
        int_or_d = |int_d;
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            data_out_q <= OUT_RESET;
            dir_q      <= DIR_RESET;
            int_en_q   <= '0;
            int_mode_q <= '0;
            int_pol_q  <= '0;
            int_both_q <= '0;
            status_q   <= '0;
            prev_q     <= '0;
            sync_q     <= '0;
            int_q      <= '0;
            int_or_q   <= 1'b0;
        end else begin
            data_out_q <= data_out_d;
            dir_q      <= dir_d;
            int_en_q   <= int_en_d;
            int_mode_q <= int_mode_d;
            int_pol_q  <= int_pol_d;
            int_both_q <= int_both_d;
            status_q   <= status_d;
            prev_q     <= prev_d;
            sync_q     <= sync_d;
            int_q      <= int_d;
            int_or_q   <= int_or_d;
        end
    end

    // Read mux; unmapped addresses return 0
    always_comb begin
        rdata = '0;
        unique case (PADDR)
            AddrDataOut: rdata[IO_NUM-1:0] = data_out_q;
            AddrDir:     rdata[IO_NUM-1:0] = dir_q;
            AddrDataIn:  rdata[IO_NUM-1:0] = cond_in;
            AddrIntEn:   rdata[IO_NUM-1:0] = int_en_q;
            AddrIntMode: rdata[IO_NUM-1:0] = int_mode_q;
            AddrIntPol:  rdata[IO_NUM-1:0] = int_pol_q;
            AddrIntBoth: rdata[IO_NUM-1:0] = int_both_q;
            AddrStatus:  rdata[IO_NUM-1:0] = status_q;
`ifdef GPIO_DEBOUNCE_EN
            AddrDebounce: rdata[15:0] = deb_cfg_q;
`endif
            default:     rdata = '0;
        endcase
        PRDATA = (PSEL & ~PWRITE) ? rdata : 32'd0;
    end

    assign GPIO_OUT = data_out_q;
    assign GPIO_OE  = dir_q;
    assign INT      = int_q;
    assign INT_OR   = int_or_q;

endmodule
